l2_arbiter: RTL

Sequencer for the shared L2 cache front-end. It arbitrates N native-bus masters (instruction-cache and data-cache back-ends) onto the single L2 native port and serialises L2 invalidation against in-flight traffic. Invalidation is issued only when the L2 is idle and its write-through buffer has drained. It replaces the simple bus merge and ad-hoc invalidate register in front of the AXI L2 cache inside the external-memory subsystem.

---
 rtl/l2_arbiter_pkg.sv | 30 +++
 rtl/l2_arb_sel.sv | 39 +++
 rtl/l2_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/l2_arbiter_pkg.sv
// l2_arbiter_pkg
//   Shared definitions for the L2 front-end sequencer: the FSM state
//   encoding and a ceiling-log2 helper used to size the grant index.
//   No ports (package).
//   Configuration macro used by the importing RTL: L2_ARB_RR_EN.

package l2_arbiter_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_GRANT    = 2'd1;
  localparam logic [1:0] ST_INV_WAIT = 2'd2;
  localparam logic [1:0] ST_INV      = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    GRANT    = ST_GRANT,
    INV_WAIT = ST_INV_WAIT,
    INV      = ST_INV
  } state_t;

  // Width of an index able to address n items. Never returns less than 1 so
  // a single-master build still gets a real (one-bit) grant register.
  function automatic int CLOG2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/l2_arb_sel.sv
// l2_arb_sel
//   Combinational winner selection. Searches i_valid starting at i_start and
//   wrapping modulo N; the first set bit found wins. Tying i_start to zero
//   gives plain fixed priority (lowest index wins).
// Ports:
//   i_valid  in  N   request vector
//   i_start  in  GW  index where the search begins (must be < N)
//   o_idx    out GW  index of the winner (0 when nothing is valid)
//   o_any    out 1   at least one request is valid

module l2_arb_sel
  import l2_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int GW = 1
) (
  input  logic [N-1:0]  i_valid,
  input  logic [GW-1:0] i_start,
  output logic [GW-1:0] o_idx,
  output logic          o_any
);

  // Walk the ring from the far end back to the start so that the last
  // assignment made is the one nearest the start pointer; this avoids a
  // break and keeps the loop a clean priority chain.
  always_comb begin
    int j;
    j     = 0;
    o_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(i_start) + k;
      if (j >= N) j = j - N;
      if (i_valid[j]) o_idx = GW'(j);
    end
  end

  assign o_any = |i_valid;

endmodule

// File: rtl/l2_arbiter.sv
// l2_arbiter
//   Sequencer in front of the shared L2 native port. Arbitrates N masters
//   onto the L2 and serialises L2 invalidation against in-flight traffic:
//   an invalidate is only issued from idle once the write-through buffer
//   has drained.
//   Configuration: define L2_ARB_RR_EN for round-robin arbitration;
//   otherwise fixed priority (lowest index wins) and no rr register exists.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-low reset
//   m_valid    in   N      per-master request valid
//   m_addr     in   N*AW   per-master address (master i at [i*AW +: AW])
//   m_wdata    in   N*DW   per-master write data
//   m_wstrb    in   N*DW/8 per-master byte strobes (zero = read)
//   m_rdata    out  DW     read data broadcast, meaningful with m_ready
//   m_ready    out  N      one-hot completion pulse
//   s_valid/s_addr/s_wdata/s_wstrb  out  request to the L2
//   s_rdata    in   DW     L2 read data
//   s_ready    in   1      L2 completion pulse
//   inv_req    in   1      invalidate request pulse
//   wtb_empty  in   1      L2 write-through buffer empty
//   force_inv  out  1      one-cycle invalidate pulse to the L2
//   busy       out  1      FSM not in IDLE

module l2_arbiter
  import l2_arbiter_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_MASTERS-1:0]         m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0]  m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]  m_wdata,
  input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb,
  output logic [DATA_W-1:0]            m_rdata,
  output logic [N_MASTERS-1:0]         m_ready,
  output logic                         s_valid,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  output logic [DATA_W/8-1:0]          s_wstrb,
  input  logic [DATA_W-1:0]            s_rdata,
  input  logic                         s_ready,
  input  logic                         inv_req,
  input  logic                         wtb_empty,
  output logic                         force_inv,
  output logic                         busy
);

  localparam int GW = CLOG2(N_MASTERS);
  localparam int SW = DATA_W / 8;

  state_t          r_state;
  state_t          w_nextState;
  logic [GW-1:0]   r_gnt;
  logic            r_invPend;
  logic [GW-1:0]   w_win;
  logic [GW-1:0]   w_start;
  logic            w_any;

`ifdef L2_ARB_RR_EN
  logic [GW-1:0]   r_rr;
  logic [GW-1:0]   w_gntInc;

  // Next search start is the master after the one just served, wrapping at
  // N_MASTERS (which need not be a power of two).
  assign w_gntInc = (r_gnt == GW'(N_MASTERS - 1)) ? '0 : r_gnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rr <= '0;
    end else if (r_state == GRANT && s_ready) begin
      r_rr <= w_gntInc;
    end
  end

  assign w_start = r_rr;
`else
  assign w_start = '0;
`endif

  l2_arb_sel #(
    .N  (N_MASTERS),
    .GW (GW)
  ) u_sel (
    .i_valid (m_valid),
    .i_start (w_start),
    .o_idx   (w_win),
    .o_any   (w_any)
  );

  // State, grant index and the pending-invalidate flag. The grant is only
  // captured when IDLE actually moves to GRANT, so a pending invalidate
  // leaves the previous index untouched. The pending flag clears on the
  // edge that enters INV; a request arriving in the INV cycle itself sets
  // it again and therefore produces a second invalidate.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_invPend <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (r_state == IDLE && !r_invPend && w_any) begin
        r_gnt <= w_win;
      end
      if (r_state == INV_WAIT && wtb_empty) begin
        r_invPend <= 1'b0;
      end else if (inv_req) begin
        r_invPend <= 1'b1;
      end
    end
  end

  // Next state and all outputs. Everything defaults to zero so that only
  // GRANT exposes master data to the L2 and only INV pulses force_inv.
  // Completion is passed straight through from s_ready.
  always_comb begin
    w_nextState = r_state;
    s_valid     = 1'b0;
    s_addr      = '0;
    s_wdata     = '0;
    s_wstrb     = '0;
    m_ready     = '0;
    m_rdata     = '0;
    force_inv   = 1'b0;
    busy        = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (r_invPend) begin
          w_nextState = INV_WAIT;
        end else if (w_any) begin
          w_nextState = GRANT;
        end
      end
      GRANT: begin
        s_valid        = m_valid[r_gnt];
        s_addr         = m_addr[r_gnt*ADDR_W +: ADDR_W];
        s_wdata        = m_wdata[r_gnt*DATA_W +: DATA_W];
        s_wstrb        = m_wstrb[r_gnt*SW +: SW];
        m_ready[r_gnt] = s_ready;
        m_rdata        = s_rdata;
        if (s_ready) w_nextState = IDLE;
      end
      INV_WAIT: begin
        if (wtb_empty) w_nextState = INV;
      end
      INV: begin
        force_inv   = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

endmodule
